// File: rtl/tl_rx_vc_pkg.sv
// Shared constants and width helpers for the RX VC header store and the FC update logic.
package tl_rx_vc_pkg;

  localparam int DW           = 32;
  localparam int HDR_DW       = 4;
  localparam int BUFFER_WIDTH = HDR_DW * DW;

  // Pointer width for a power-of-two FIFO depth: address bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // VC index width, never narrower than one bit.
  function automatic int vc_sel_width(input int num_vc);
    return (num_vc > 1) ? $clog2(num_vc) : 1;
  endfunction

endpackage

// File: rtl/tl_rx_vc_mc_hdr_buffer_if.sv
// Write/read/status bundle of the multi-channel header store.
// master = RX TLP processor + VC arbiter side, slave = the header store.
interface tl_rx_vc_mc_hdr_buffer_if
  import tl_rx_vc_pkg::*;
#(
  parameter int NUM_VC   = 2,
  parameter int VC_DEPTH = 32
);

  localparam int VC_SEL_W = vc_sel_width(NUM_VC);
  localparam int CNT_W    = ptr_width(VC_DEPTH);

  logic [VC_SEL_W-1:0]     i_w_vc;
  logic                    i_w_hdr_en;
  logic                    i_w_hdr_inc;
  logic [BUFFER_WIDTH-1:0] i_w_tlp_hdr;
  logic [VC_SEL_W-1:0]     i_r_vc;
  logic                    i_r_hdr_inc;
  logic [NUM_VC-1:0]       i_flush;

  logic [BUFFER_WIDTH-1:0] o_r_tlp_hdr;
  logic                    o_r_hdr_valid;
  logic [NUM_VC-1:0]       o_vc_empty;
  logic [NUM_VC-1:0]       o_vc_full;
  logic [NUM_VC*CNT_W-1:0] o_vc_count;
  logic [NUM_VC-1:0]       o_hdr_credit_ret;
  logic [NUM_VC-1:0]       o_ovf_err;
  logic [NUM_VC-1:0]       o_udf_err;

  modport master (
    output i_w_vc, i_w_hdr_en, i_w_hdr_inc, i_w_tlp_hdr, i_r_vc, i_r_hdr_inc, i_flush,
    input  o_r_tlp_hdr, o_r_hdr_valid, o_vc_empty, o_vc_full, o_vc_count,
           o_hdr_credit_ret, o_ovf_err, o_udf_err
  );

  modport slave (
    input  i_w_vc, i_w_hdr_en, i_w_hdr_inc, i_w_tlp_hdr, i_r_vc, i_r_hdr_inc, i_flush,
    output o_r_tlp_hdr, o_r_hdr_valid, o_vc_empty, o_vc_full, o_vc_count,
           o_hdr_credit_ret, o_ovf_err, o_udf_err
  );

endinterface

// File: rtl/tl_rx_vc_hdr_ptr_ctrl.sv
// Pointer controller for one VC: head/tail with wrap bit, flags, occupancy,
// sticky overflow/underflow errors and the registered header-credit pulse.
module tl_rx_vc_hdr_ptr_ctrl
  import tl_rx_vc_pkg::*;
#(
  parameter  int VC_DEPTH = 32,
  localparam int PTR_W    = ptr_width(VC_DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_commit,     // commit request aimed at this VC
  input  logic             i_pop,        // pop request aimed at this VC
  input  logic             i_flush,
  output logic [PTR_W-2:0] o_head_addr,
  output logic [PTR_W-2:0] o_tail_addr,
  output logic             o_empty,
  output logic             o_full,
  output logic [PTR_W-1:0] o_count,
  output logic             o_credit_ret,
  output logic             o_ovf_err,
  output logic             o_udf_err
);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic             credit_q, credit_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             empty, full;

  // Status flags straight from the registered pointers.
  always_comb begin
    empty = (head_q == tail_q);
    full  = (head_q[PTR_W-2:0] == tail_q[PTR_W-2:0]) &&
            (head_q[PTR_W-1] != tail_q[PTR_W-1]);
  end

  // Next pointer/error/credit state; flush overrides commit and pop.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    head_d   = head_q;
    tail_d   = tail_q;
    credit_d = 1'b0;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (i_flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (i_commit) begin
        if (full) ovf_d  = 1'b1;
        else      tail_d = tail_q + PTR_W'(1);   // carry into the MSB is the wrap toggle
      end
      if (i_pop) begin
        if (empty) begin
          udf_d = 1'b1;
        end else begin
          head_d   = head_q + PTR_W'(1);
          credit_d = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (i_rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign o_head_addr  = head_q[PTR_W-2:0];
  assign o_tail_addr  = tail_q[PTR_W-2:0];
  assign o_empty      = empty;
  assign o_full       = full;
  assign o_count      = tail_q - head_q;
  assign o_credit_ret = credit_q;
  assign o_ovf_err    = ovf_q;
  assign o_udf_err    = udf_q;

endmodule

// File: rtl/tl_rx_vc_mc_hdr_buffer.sv
// Multi-channel TLP header store: NUM_VC header FIFOs sharing one memory,
// addressed as {vc, slot}. Writes are registered, the head read is combinational.
module tl_rx_vc_mc_hdr_buffer
  import tl_rx_vc_pkg::*;
#(
  parameter int NUM_VC   = 2,
  parameter int VC_DEPTH = 32
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  tl_rx_vc_mc_hdr_buffer_if.slave        bus
);

  localparam int PTR_W     = ptr_width(VC_DEPTH);
  localparam int CNT_W     = PTR_W;
  localparam int VC_SEL_W  = vc_sel_width(NUM_VC);
  localparam int ADDR_W    = VC_SEL_W + PTR_W - 1;
  localparam int MEM_DEPTH = NUM_VC * VC_DEPTH;

  logic [BUFFER_WIDTH-1:0] mem [MEM_DEPTH];

  logic [NUM_VC-1:0] commit_req, pop_req;
  logic [NUM_VC-1:0] vc_empty, vc_full, credit_ret, ovf_err, udf_err;
  logic [PTR_W-2:0]  head_addr [NUM_VC];
  logic [PTR_W-2:0]  tail_addr [NUM_VC];
  logic [CNT_W-1:0]  vc_count  [NUM_VC];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;

  // One pointer controller per VC; out-of-range VC indices match no instance.
  for (genvar k = 0; k < NUM_VC; k++) begin : g_vc
    assign commit_req[k] = bus.i_w_hdr_inc && (int'(bus.i_w_vc) == k);
    assign pop_req[k]    = bus.i_r_hdr_inc && (int'(bus.i_r_vc) == k);

    tl_rx_vc_hdr_ptr_ctrl #(.VC_DEPTH(VC_DEPTH)) u_ptr (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_commit     (commit_req[k]),
      .i_pop        (pop_req[k]),
      .i_flush      (bus.i_flush[k]),
      .o_head_addr  (head_addr[k]),
      .o_tail_addr  (tail_addr[k]),
      .o_empty      (vc_empty[k]),
      .o_full       (vc_full[k]),
      .o_count      (vc_count[k]),
      .o_credit_ret (credit_ret[k]),
      .o_ovf_err    (ovf_err[k]),
      .o_udf_err    (udf_err[k])
    );

    assign bus.o_vc_count[k*CNT_W +: CNT_W] = vc_count[k];
  end

  // VC muxing of the write slot (tail) and the read slot (head).
  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = '0;
    rd_addr  = '0;
    rd_valid = 1'b0;
    for (int k = 0; k < NUM_VC; k++) begin
      if (int'(bus.i_w_vc) == k) begin
        wr_en   = bus.i_w_hdr_en && !vc_full[k];   // a full VC's tail slot is its head
        wr_addr = {VC_SEL_W'(k), tail_addr[k]};
      end
      if (int'(bus.i_r_vc) == k) begin
        rd_addr  = {VC_SEL_W'(k), head_addr[k]};
        rd_valid = !vc_empty[k];
      end
    end
  end

  // Header memory write port.
  always_ff @(posedge i_clk) begin
    // NOTE: the memory has no reset; contents only matter once a pointer marks them valid.
    if (wr_en) mem[wr_addr] <= bus.i_w_tlp_hdr;
  end

  assign bus.o_r_tlp_hdr      = mem[rd_addr];
  assign bus.o_r_hdr_valid    = rd_valid;
  assign bus.o_vc_empty       = vc_empty;
  assign bus.o_vc_full        = vc_full;
  assign bus.o_hdr_credit_ret = credit_ret;
  assign bus.o_ovf_err        = ovf_err;
  assign bus.o_udf_err        = udf_err;

endmodule

// File: tb/tb_tl_rx_vc_mc_hdr_buffer.sv
// Self-checking bench for the multi-channel header store: directed scenarios plus a
// randomized run, all compared against per-VC queue models of the FIFOs.
module tb_tl_rx_vc_mc_hdr_buffer;
  import tl_rx_vc_pkg::*;

  localparam int NUM_VC   = 2;
  localparam int VC_DEPTH = 32;
  localparam int CNT_W    = ptr_width(VC_DEPTH);
  localparam int VC_SEL_W = vc_sel_width(NUM_VC);
  localparam int BW       = BUFFER_WIDTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tl_rx_vc_mc_hdr_buffer_if #(.NUM_VC(NUM_VC), .VC_DEPTH(VC_DEPTH)) bus ();

  tl_rx_vc_mc_hdr_buffer #(.NUM_VC(NUM_VC), .VC_DEPTH(VC_DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: committed headers per VC, the staged tail slot, sticky errors.
  logic [BW-1:0]     mq [NUM_VC][$];
  logic [BW-1:0]     stage [NUM_VC];
  logic [NUM_VC-1:0] m_ovf, m_udf;

  function automatic logic [BW-1:0] rand_hdr();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drive_idle();
    bus.i_w_vc      = '0;
    bus.i_w_hdr_en  = 1'b0;
    bus.i_w_hdr_inc = 1'b0;
    bus.i_w_tlp_hdr = '0;
    bus.i_r_vc      = '0;
    bus.i_r_hdr_inc = 1'b0;
    bus.i_flush     = '0;
  endtask

  task automatic apply_reset();
    drive_idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < NUM_VC; k++) mq[k].delete();
    m_ovf = '0;
    m_udf = '0;
  endtask

  // One clock of stimulus: checks the combinational head read before the edge, advances
  // the model, then checks flags, counts, credits and errors after the edge.
  task automatic do_cycle(input int wvc, input bit en, input bit inc, input logic [BW-1:0] data,
                          input int rvc, input bit pop, input logic [NUM_VC-1:0] fl);
    logic [NUM_VC-1:0] exp_credit;
    bus.i_w_vc      = VC_SEL_W'(wvc);
    bus.i_w_hdr_en  = en;
    bus.i_w_hdr_inc = inc;
    bus.i_w_tlp_hdr = data;
    bus.i_r_vc      = VC_SEL_W'(rvc);
    bus.i_r_hdr_inc = pop;
    bus.i_flush     = fl;
    #1;
    checks++;
    if (bus.o_r_hdr_valid !== (mq[rvc].size() != 0)) begin
      failures++;
      $display("FAIL rd_valid vc%0d got=%b exp=%b", rvc, bus.o_r_hdr_valid, mq[rvc].size() != 0);
    end
    if (mq[rvc].size() != 0) begin
      checks++;
      if (bus.o_r_tlp_hdr !== mq[rvc][0]) begin
        failures++;
        $display("FAIL rd_data vc%0d got=%h exp=%h", rvc, bus.o_r_tlp_hdr, mq[rvc][0]);
      end
    end
    exp_credit = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      automatic bit is_full  = (mq[k].size() == VC_DEPTH);
      automatic bit is_empty = (mq[k].size() == 0);
      automatic bit do_com   = inc && (wvc == k);
      automatic bit do_pop   = pop && (rvc == k);
      if (en && (wvc == k) && !is_full) stage[k] = data;
      if (fl[k]) begin
        mq[k].delete();
      end else begin
        if (do_com && is_full)  m_ovf[k] = 1'b1;
        if (do_pop && is_empty) m_udf[k] = 1'b1;
        if (do_pop && !is_empty) begin
          void'(mq[k].pop_front());
          exp_credit[k] = 1'b1;
        end
        if (do_com && !is_full) mq[k].push_back(stage[k]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (bus.o_hdr_credit_ret !== exp_credit) begin
      failures++;
      $display("FAIL credit_ret got=%b exp=%b", bus.o_hdr_credit_ret, exp_credit);
    end
    checks++;
    if (bus.o_ovf_err !== m_ovf || bus.o_udf_err !== m_udf) begin
      failures++;
      $display("FAIL err_flags ovf got=%b exp=%b udf got=%b exp=%b",
               bus.o_ovf_err, m_ovf, bus.o_udf_err, m_udf);
    end
    for (int k = 0; k < NUM_VC; k++) begin
      checks++;
      if (bus.o_vc_count[k*CNT_W +: CNT_W] !== CNT_W'(mq[k].size()) ||
          bus.o_vc_empty[k] !== (mq[k].size() == 0) ||
          bus.o_vc_full[k]  !== (mq[k].size() == VC_DEPTH)) begin
        failures++;
        $display("FAIL vc%0d_status count got=%0d exp=%0d empty got=%b full got=%b",
                 k, bus.o_vc_count[k*CNT_W +: CNT_W], mq[k].size(),
                 bus.o_vc_empty[k], bus.o_vc_full[k]);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (bus.o_vc_empty !== '1 || bus.o_vc_full !== '0 || bus.o_vc_count !== '0) begin
      failures++;
      $display("FAIL reset_status empty=%b full=%b count=%h exp empty=11 full=00 count=0",
               bus.o_vc_empty, bus.o_vc_full, bus.o_vc_count);
    end
    checks++;
    if (bus.o_r_hdr_valid !== 1'b0 || bus.o_hdr_credit_ret !== '0 ||
        bus.o_ovf_err !== '0 || bus.o_udf_err !== '0) begin
      failures++;
      $display("FAIL reset_outputs valid=%b credit=%b ovf=%b udf=%b exp all 0",
               bus.o_r_hdr_valid, bus.o_hdr_credit_ret, bus.o_ovf_err, bus.o_udf_err);
    end
    for (int i = 0; i < 4; i++) do_cycle(0, 0, 0, '0, i % 2, 0, '0);
  endtask

  task automatic test_fill_vc1();
    int credits = 0;
    for (int i = 0; i < VC_DEPTH; i++) do_cycle(1, 1, 1, BW'(i), 0, 0, '0);
    checks++;
    if (bus.o_vc_full[1] !== 1'b1 || bus.o_vc_count[CNT_W +: CNT_W] !== CNT_W'(VC_DEPTH) ||
        bus.o_vc_empty[0] !== 1'b1) begin
      failures++;
      $display("FAIL fill_vc1 full1=%b count1=%0d empty0=%b exp 1/32/1",
               bus.o_vc_full[1], bus.o_vc_count[CNT_W +: CNT_W], bus.o_vc_empty[0]);
    end
    do_cycle(1, 1, 1, {BW{1'b1}}, 0, 0, '0);
    checks++;
    if (bus.o_ovf_err[1] !== 1'b1) begin
      failures++;
      $display("FAIL ovf_vc1 got=%b exp=1", bus.o_ovf_err[1]);
    end
    for (int i = 0; i < VC_DEPTH; i++) begin
      bus.i_r_vc = 1'b1;
      #1;
      checks++;
      if (bus.o_r_tlp_hdr !== BW'(i)) begin
        failures++;
        $display("FAIL drain_order idx=%0d got=%h exp=%h", i, bus.o_r_tlp_hdr, BW'(i));
      end
      do_cycle(0, 0, 0, '0, 1, 1, '0);
      credits += int'(bus.o_hdr_credit_ret[1]);
    end
    checks++;
    if (credits != VC_DEPTH) begin
      failures++;
      $display("FAIL credit_total got=%0d exp=%0d", credits, VC_DEPTH);
    end
  endtask

  task automatic test_wrap();
    do_cycle(0, 1, 1, rand_hdr(), 0, 0, '0);
    for (int i = 0; i < 40; i++) begin
      do_cycle(0, 1, 1, rand_hdr(), 0, 1, '0);
      checks++;
      if (bus.o_vc_count[0 +: CNT_W] !== CNT_W'(1) || bus.o_r_hdr_valid !== 1'b1) begin
        failures++;
        $display("FAIL wrap_count iter=%0d count=%0d valid=%b exp 1/1",
                 i, bus.o_vc_count[0 +: CNT_W], bus.o_r_hdr_valid);
      end
    end
    do_cycle(0, 0, 0, '0, 0, 1, '0);
  endtask

  task automatic test_underflow_staging();
    logic [BW-1:0] hdr_a, hdr_b;
    do_cycle(0, 0, 0, '0, 0, 1, '0);
    checks++;
    if (bus.o_udf_err[0] !== 1'b1 || bus.o_hdr_credit_ret[0] !== 1'b0 ||
        bus.o_vc_count[0 +: CNT_W] !== '0) begin
      failures++;
      $display("FAIL udf_vc0 udf=%b credit=%b count=%0d exp 1/0/0",
               bus.o_udf_err[0], bus.o_hdr_credit_ret[0], bus.o_vc_count[0 +: CNT_W]);
    end
    hdr_a = rand_hdr();
    hdr_b = ~hdr_a;
    do_cycle(0, 1, 0, hdr_a, 0, 0, '0);
    do_cycle(0, 1, 0, hdr_b, 0, 0, '0);
    do_cycle(0, 0, 1, '0, 0, 0, '0);
    bus.i_r_vc = '0;
    #1;
    checks++;
    if (bus.o_r_tlp_hdr !== hdr_b) begin
      failures++;
      $display("FAIL staging_head got=%h exp=%h", bus.o_r_tlp_hdr, hdr_b);
    end
    do_cycle(0, 0, 0, '0, 0, 1, '0);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 2; i++) do_cycle(0, 1, 1, rand_hdr(), 0, 0, '0);
    for (int i = 0; i < 5; i++) do_cycle(1, 1, 1, rand_hdr(), 0, 0, '0);
    do_cycle(1, 1, 1, rand_hdr(), 1, 1, 2'b10);
    checks++;
    if (bus.o_vc_count[CNT_W +: CNT_W] !== '0 || bus.o_vc_empty[1] !== 1'b1 ||
        bus.o_hdr_credit_ret[1] !== 1'b0 || bus.o_vc_count[0 +: CNT_W] !== CNT_W'(2)) begin
      failures++;
      $display("FAIL flush_vc1 count1=%0d empty1=%b credit1=%b count0=%0d exp 0/1/0/2",
               bus.o_vc_count[CNT_W +: CNT_W], bus.o_vc_empty[1],
               bus.o_hdr_credit_ret[1], bus.o_vc_count[0 +: CNT_W]);
    end
    for (int i = 0; i < 2; i++) do_cycle(0, 0, 0, '0, 0, 1, '0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      int  p_push = (i < 300) ? 75 : 30;
      bit  inc    = ($urandom_range(0, 99) < p_push);
      bit  en     = inc || ($urandom_range(0, 3) == 0);
      bit  pop    = ($urandom_range(0, 99) < (100 - p_push));
      logic [NUM_VC-1:0] fl = ($urandom_range(0, 63) == 0) ? NUM_VC'($urandom()) : '0;
      do_cycle($urandom_range(0, NUM_VC-1), en, inc, rand_hdr(),
               $urandom_range(0, NUM_VC-1), pop, fl);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) do_cycle(0, 1, 1, rand_hdr(), 0, 0, '0);
    for (int i = 0; i < 4; i++) do_cycle(1, 1, 1, rand_hdr(), 0, 0, '0);
    do_cycle(1, 0, 0, '0, 1, 1, '0);
    apply_reset();
    checks++;
    if (bus.o_vc_empty !== '1 || bus.o_vc_count !== '0 || bus.o_vc_full !== '0 ||
        bus.o_ovf_err !== '0 || bus.o_udf_err !== '0 || bus.o_r_hdr_valid !== 1'b0 ||
        bus.o_hdr_credit_ret !== '0) begin
      failures++;
      $display("FAIL reset_mid empty=%b count=%h full=%b ovf=%b udf=%b valid=%b credit=%b",
               bus.o_vc_empty, bus.o_vc_count, bus.o_vc_full, bus.o_ovf_err,
               bus.o_udf_err, bus.o_r_hdr_valid, bus.o_hdr_credit_ret);
    end
    do_cycle(1, 1, 1, rand_hdr(), 0, 0, '0);
    do_cycle(0, 0, 0, '0, 1, 1, '0);
  endtask

  initial begin
    rst = 1'b1;
    m_ovf = '0;
    m_udf = '0;
    for (int k = 0; k < NUM_VC; k++) stage[k] = '0;
    drive_idle();
    test_reset();
    test_fill_vc1();
    test_wrap();
    test_underflow_staging();
    test_flush();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
